tcbm_drive_link: RTL and testbench
==================================

Name: tcbm_drive_link

Overview:
- Drive-side TCBM protocol engine. It sits directly downstream of the Plus/4-side 6523 port block and consumes its port A (8-bit data), port B[1:0] (status) and port C[7:6] (DAV/ACK) lines across the TCBM cable.
- It converts the two-phase DAV/ACK byte handshake into ready/valid streams for the SD controller.
- It returns read bytes and 2-bit status to the computer.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the DAV input synchronizer (minimum 2).
- TIMEOUT, 4095, clocks to wait for the next host edge or local ready before aborting.
- TO_W, 12, timeout counter width; TIMEOUT must fit in TO_W bits.

Ports:
- phi2  in  1  drive clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- tcbm_din  in  8  port A as sampled from the cable.
- tcbm_dout  out  8  byte driven onto port A during reads.
- tcbm_doe  out  1  port A output enable (pad tristate control lives outside this block).
- tcbm_dav  in  1  DAV from computer port C7, active-low, asynchronous.
- tcbm_ack  out  1  ACK to computer port C6, active-low.
- tcbm_st  out  2  status to computer port B[1:0].
- rx_valid  out  1  received byte available.
- rx_ready  in  1  consumer accepts the received byte.
- rx_data  out  8  received byte.
- rx_is_cmd  out  1  1 = command byte (0x81 phase), 0 = data byte (0x82 phase).
- tx_valid  in  1  producer offers a read byte.
- tx_ready  out  1  read byte taken.
- tx_data  in  8  read byte.
- tx_status  in  2  status to present with the read byte.
- timeout_err  out  1  one-cycle pulse when a transaction is aborted on timeout.

Behaviour:
- Reset values: tcbm_ack=1, tcbm_doe=0, tcbm_dout=0x00, tcbm_st=2'b00, rx_valid=0, rx_data=0x00, rx_is_cmd=0, tx_ready=0, timeout_err=0, state=IDLE. The synchronizer chain resets to 1.
- dav_s is tcbm_dav after SYNC_STAGES flops. Edge detection uses dav_s against its previous value, so the earliest response is SYNC_STAGES+1 clocks after the pin changes.
- A transaction is a code phase followed by a payload phase. Each phase follows the same sequence:
  - DAV falls; the drive latches or drives and sets ACK=0.
  - DAV rises; the drive sets ACK=1.
- Code values: 0x81 = command write, 0x82 = data write, 0x83 = data read, 0x84 = status read. Any other code is acknowledged with no payload phase, and the engine returns to IDLE.
- States and transitions:
  - IDLE: on DAV fall, latch tcbm_din as code, set ack=0, go to C_REL.
  - C_REL: on DAV rise, set ack=1. Next state by code: 0x81/0x82 → W_WAIT; 0x83/0x84 → R_LOAD; otherwise → IDLE.
  - W_WAIT: on DAV fall, latch tcbm_din into rx_data, set rx_is_cmd=(code==0x81), set rx_valid=1, go to W_HOLD. Ack stays 1.
  - W_HOLD: on the rx_valid&&rx_ready cycle, clear rx_valid, set ack=0, go to W_REL. Flow control works by ACK not falling until the consumer takes the byte.
  - W_REL: on DAV rise, set ack=1, go to IDLE.
  - R_LOAD: assert tx_ready when tx_valid=1; on that handshake cycle:
    - register tcbm_dout = tx_data for 0x83, or 0x00 for 0x84;
    - register tcbm_st = tx_status;
    - set doe=1;
    - go to R_WAIT.
  - R_WAIT: on DAV fall, set ack=0, go to R_REL.
  - R_REL: on DAV rise, set ack=1, doe=0, tcbm_st=00, go to IDLE.
- tx_ready is a single-cycle pulse and is combinational from state R_LOAD && tx_valid.
- Timeout:
  - The counter clears on every state change.
  - It increments in every non-IDLE state.
  - At TIMEOUT it forces: ack=1, doe=0, rx_valid=0, tcbm_st=2'b01 (held until the next DAV fall in IDLE), state=IDLE, and pulses timeout_err.
- DAV glitches shorter than one synchronized sample are ignored. A DAV edge of the wrong polarity for the current state is ignored.
- rx_data and rx_is_cmd stay stable while rx_valid=1. tcbm_dout stays stable while doe=1.
- Asynchronous reset mid-transaction returns to IDLE immediately with the reset values; the computer sees ACK high.

Test Plan:
- Command write: DAV low with 0x81, DAV high; then DAV low with 0x55, rx_ready=1 → rx_valid for 1 cycle with rx_data=0x55 and rx_is_cmd=1; ACK low 1 cycle after the accept and high after DAV rises; state IDLE.
- Backpressure: code 0x82, data 0xA3, rx_ready=0 for 50 clocks → ACK stays 1 and rx_data=0xA3 is held; rx_ready=1 → ACK falls next cycle.
- Read: code 0x83, tx_valid=1, tx_data=0x7E, tx_status=2'b10 → doe=1, dout=0x7E, st=10 before the DAV fall; after DAV rises → doe=0, st=00.
- Unknown code 0x90: ACK cycles once, no rx_valid, back to IDLE; a following 0x82 transaction completes normally.
- Timeout: TIMEOUT=15, code 0x83 with tx_valid never set → after 15 clocks timeout_err pulses, st=01, doe=0, ACK=1; st returns to 00 on the next DAV fall.
- Reset during W_HOLD → ACK=1, rx_valid=0, state IDLE in the same cycle; a new transaction then succeeds.

Source files
------------

// File: rtl/tcbm_drive_link.sv
// Drive-side TCBM protocol engine: turns the two-phase DAV/ACK cable handshake
// into ready/valid byte streams and returns read bytes plus status to the host.
module tcbm_drive_link #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4095,
    parameter int TO_W        = 12
) (
    input  logic       phi2,
    input  logic       reset,
    input  logic [7:0] tcbm_din,
    output logic [7:0] tcbm_dout,
    output logic       tcbm_doe,
    input  logic       tcbm_dav,
    output logic       tcbm_ack,
    output logic [1:0] tcbm_st,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_is_cmd,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic [1:0] tx_status,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_C_REL,
        S_W_WAIT,
        S_W_HOLD,
        S_W_REL,
        S_R_LOAD,
        S_R_WAIT,
        S_R_REL
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] r_dav_sync;
    logic                   r_dav_prev;
    state_t                 r_state;
    logic [7:0]             r_code;
    logic [TO_W-1:0]        r_to_cnt;
    logic                   r_ack;
    logic                   r_doe;
    logic [7:0]             r_dout;
    logic [1:0]             r_st;
    logic                   r_rx_valid;
    logic [7:0]             r_rx_data;
    logic                   r_rx_is_cmd;
    logic                   r_to_err;

    logic w_dav_s;
    logic w_dav_fall;
    logic w_dav_rise;
    logic w_tx_ready;

    assign w_dav_s    = r_dav_sync[SYNC_STAGES-1];
    assign w_dav_fall = r_dav_prev & ~w_dav_s;
    assign w_dav_rise = ~r_dav_prev & w_dav_s;
    assign w_tx_ready = (r_state == S_R_LOAD) && tx_valid;

    // DAV is asynchronous to phi2; the chain idles high like the cable line.
    always_ff @(posedge phi2 or posedge reset) begin
        if (reset) begin
            r_dav_sync <= '1;
            r_dav_prev <= 1'b1;
        end else begin
            r_dav_sync <= {r_dav_sync[SYNC_STAGES-2:0], tcbm_dav};
            r_dav_prev <= w_dav_s;
        end
    end

    always_ff @(posedge phi2 or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_code      <= 8'h00;
            r_to_cnt    <= '0;
            r_ack       <= 1'b1;
            r_doe       <= 1'b0;
            r_dout      <= 8'h00;
            r_st        <= 2'b00;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_is_cmd <= 1'b0;
            r_to_err    <= 1'b0;
        end else begin
            r_to_err <= 1'b0;
            r_to_cnt <= (r_state == S_IDLE) ? '0 : r_to_cnt + 1'b1;
            // Abort wins over any transition due in the same cycle.
            if (r_state != S_IDLE && r_to_cnt == TO_LAST) begin
                r_state    <= S_IDLE;
                r_to_cnt   <= '0;
                r_ack      <= 1'b1;
                r_doe      <= 1'b0;
                r_rx_valid <= 1'b0;
                r_st       <= 2'b01;
                r_to_err   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_dav_fall) begin
                            r_code  <= tcbm_din;
                            r_ack   <= 1'b0;
                            r_st    <= 2'b00;
                            r_state <= S_C_REL;
                        end
                    end
                    S_C_REL: begin
                        if (w_dav_rise) begin
                            r_ack    <= 1'b1;
                            r_to_cnt <= '0;
                            if (r_code == 8'h81 || r_code == 8'h82)
                                r_state <= S_W_WAIT;
                            else if (r_code == 8'h83 || r_code == 8'h84)
                                r_state <= S_R_LOAD;
                            else
                                r_state <= S_IDLE;
                        end
                    end
                    S_W_WAIT: begin
                        if (w_dav_fall) begin
                            r_rx_data   <= tcbm_din;
                            r_rx_is_cmd <= (r_code == 8'h81);
                            r_rx_valid  <= 1'b1;
                            r_to_cnt    <= '0;
                            r_state     <= S_W_HOLD;
                        end
                    end
                    S_W_HOLD: begin
                        // ACK is withheld until the consumer takes the byte.
                        if (r_rx_valid && rx_ready) begin
                            r_rx_valid <= 1'b0;
                            r_ack      <= 1'b0;
                            r_to_cnt   <= '0;
                            r_state    <= S_W_REL;
                        end
                    end
                    S_W_REL: begin
                        if (w_dav_rise) begin
                            r_ack   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    S_R_LOAD: begin
                        if (tx_valid) begin
                            r_dout   <= (r_code == 8'h83) ? tx_data : 8'h00;
                            r_st     <= tx_status;
                            r_doe    <= 1'b1;
                            r_to_cnt <= '0;
                            r_state  <= S_R_WAIT;
                        end
                    end
                    S_R_WAIT: begin
                        if (w_dav_fall) begin
                            r_ack    <= 1'b0;
                            r_to_cnt <= '0;
                            r_state  <= S_R_REL;
                        end
                    end
                    S_R_REL: begin
                        if (w_dav_rise) begin
                            r_ack   <= 1'b1;
                            r_doe   <= 1'b0;
                            r_st    <= 2'b00;
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign tcbm_dout   = r_dout;
    assign tcbm_doe    = r_doe;
    assign tcbm_ack    = r_ack;
    assign tcbm_st     = r_st;
    assign rx_valid    = r_rx_valid;
    assign rx_data     = r_rx_data;
    assign rx_is_cmd   = r_rx_is_cmd;
    assign tx_ready    = w_tx_ready;
    assign timeout_err = r_to_err;

endmodule

// File: tb/tb_tcbm_drive_link.sv
// Scoreboard bench for tcbm_drive_link: a host model drives the cable, queues
// hold the expected bytes, and monitors compare whenever the DUT presents data.
module tb_tcbm_drive_link;

    localparam int TIMEOUT = 63;

    logic       phi2 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tcbm_din = 8'h00;
    logic [7:0] tcbm_dout;
    logic       tcbm_doe;
    logic       tcbm_dav = 1'b1;
    logic       tcbm_ack;
    logic [1:0] tcbm_st;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_is_cmd;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic [1:0] tx_status = 2'b00;
    logic       timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_timeouts = 0;
    int rx_mode = 0;
    logic       rd_req = 1'b0;
    logic [7:0] prod_data = 8'h00;
    logic [1:0] prod_st = 2'b00;
    logic [8:0] rx_exp[$];
    logic [9:0] rd_exp[$];

    tcbm_drive_link #(.SYNC_STAGES(2), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .phi2(phi2), .reset(reset), .tcbm_din(tcbm_din), .tcbm_dout(tcbm_dout),
        .tcbm_doe(tcbm_doe), .tcbm_dav(tcbm_dav), .tcbm_ack(tcbm_ack), .tcbm_st(tcbm_st),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_is_cmd(rx_is_cmd),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_status(tx_status),
        .timeout_err(timeout_err)
    );

    always #5 phi2 = ~phi2;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    task automatic wait_ack(input logic lvl, input string nm);
        int n = 0;
        do begin
            @(negedge phi2);
            n++;
        end while (tcbm_ack !== lvl && n < 200);
        check(nm, tcbm_ack, lvl);
    endtask

    // One host phase: drop DAV with a byte, wait ACK low, raise DAV, wait ACK high.
    task automatic phase(input logic [7:0] d, input string nm);
        @(posedge phi2); #1;
        tcbm_din = d;
        tcbm_dav = 1'b0;
        wait_ack(1'b0, {nm, " ack low"});
        @(posedge phi2); #1;
        tcbm_dav = 1'b1;
        wait_ack(1'b1, {nm, " ack high"});
    endtask

    task automatic wr(input logic [7:0] code, input logic [7:0] d);
        rx_exp.push_back({code == 8'h81, d});
        phase(code, "wr code");
        phase(d, "wr data");
    endtask

    task automatic rd(input logic [7:0] code, input logic [7:0] d, input logic [1:0] s);
        int n = 0;
        logic [7:0] exp_d;
        exp_d = (code == 8'h83) ? d : 8'h00;
        prod_data = d;
        prod_st = s;
        rd_exp.push_back({exp_d, s});
        rd_req = 1'b1;
        phase(code, "rd code");
        do begin
            @(negedge phi2);
            n++;
        end while (!tcbm_doe && n < 200);
        check("rd doe before dav", tcbm_doe, 1);
        check("rd dout before dav", tcbm_dout, exp_d);
        check("rd st before dav", tcbm_st, s);
        phase(8'($urandom), "rd payload");
        check("rd doe released", tcbm_doe, 0);
        check("rd st released", tcbm_st, 0);
        n = 0;
        while (rd_req && n < 200) begin
            @(negedge phi2);
            n++;
        end
        check("rd producer done", rd_req, 0);
    endtask

    task automatic unk(input logic [7:0] code);
        phase(code, "unknown code");
        repeat (4) @(negedge phi2);
        check("unknown ack idle", tcbm_ack, 1);
    endtask

    // Consumer: random backpressure unless a test pins rx_ready.
    initial forever begin
        @(posedge phi2); #1;
        case (rx_mode)
            0: rx_ready = ($urandom_range(0, 3) != 0);
            1: rx_ready = 1'b0;
            default: rx_ready = 1'b1;
        endcase
    end

    // Producer: offers the staged read byte after a random delay.
    initial forever begin
        @(posedge phi2); #1;
        if (rd_req) begin
            int n = 0;
            repeat ($urandom_range(0, 3)) @(posedge phi2);
            #1;
            tx_valid = 1'b1;
            tx_data = prod_data;
            tx_status = prod_st;
            do begin
                @(negedge phi2);
                n++;
            end while (!tx_ready && n < 500);
            if (!tx_ready) fail("producer tx_ready never seen");
            @(posedge phi2); #1;
            tx_valid = 1'b0;
            tx_data = 8'($urandom);
            tx_status = 2'($urandom);
            rd_req = 1'b0;
        end
    end

    // Received-byte monitor.
    initial forever begin
        @(negedge phi2);
        if (rx_valid && rx_exp.size() == 0) fail("rx_valid with nothing expected");
        else if (rx_valid && rx_ready) begin
            logic [8:0] e;
            e = rx_exp.pop_front();
            check("rx {is_cmd,data}", {rx_is_cmd, rx_data}, e);
        end
    end

    // Read-byte monitor: the host latches port A/B when ACK falls with the bus driven.
    initial begin
        logic prev_ack = 1'b1;
        forever begin
            @(negedge phi2);
            if (prev_ack && !tcbm_ack && tcbm_doe) begin
                if (rd_exp.size() == 0) fail("read byte with nothing expected");
                else begin
                    logic [9:0] e;
                    e = rd_exp.pop_front();
                    check("rd {dout,st} at ack", {tcbm_dout, tcbm_st}, e);
                end
            end
            if (timeout_err) n_timeouts++;
            prev_ack = tcbm_ack;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] c;
        logic [7:0] d;
        repeat (3) @(posedge phi2);
        @(negedge phi2);
        check("reset ack", tcbm_ack, 1);
        check("reset doe", tcbm_doe, 0);
        check("reset dout", tcbm_dout, 0);
        check("reset st", tcbm_st, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 0);
        check("reset rx_is_cmd", rx_is_cmd, 0);
        check("reset tx_ready", tx_ready, 0);
        check("reset timeout_err", timeout_err, 0);
        @(posedge phi2); #1;
        reset = 1'b0;

        wr(8'h81, 8'h55);

        // Backpressure: byte held, ACK high until the consumer accepts.
        rx_mode = 1;
        rx_exp.push_back({1'b0, 8'hA3});
        phase(8'h82, "bp code");
        @(posedge phi2); #1;
        tcbm_din = 8'hA3;
        tcbm_dav = 1'b0;
        n = 0;
        do begin
            @(negedge phi2);
            n++;
        end while (!rx_valid && n < 200);
        check("bp rx_valid", rx_valid, 1);
        begin
            logic held = 1'b1;
            repeat (50) begin
                @(negedge phi2);
                if (tcbm_ack !== 1'b1 || rx_data !== 8'hA3 || rx_valid !== 1'b1) held = 1'b0;
            end
            check("bp ack high and byte held", held, 1);
        end
        @(posedge phi2); #1;
        rx_mode = 2;
        rx_ready = 1'b1;
        @(negedge phi2);
        check("bp ack before accept", tcbm_ack, 1);
        @(negedge phi2);
        check("bp ack after accept", tcbm_ack, 0);
        check("bp rx_valid cleared", rx_valid, 0);
        @(posedge phi2); #1;
        tcbm_dav = 1'b1;
        wait_ack(1'b1, "bp release");
        rx_mode = 0;

        rd(8'h83, 8'h7E, 2'b10);
        rd(8'h84, 8'h5A, 2'b11);

        unk(8'h90);
        wr(8'h82, 8'hC4);

        // Timeout in R_LOAD with no producer.
        phase(8'h83, "to code");
        n = 0;
        do begin
            @(negedge phi2);
            n++;
        end while (!timeout_err && n < 200);
        check("timeout latency", n, TIMEOUT);
        check("timeout st", tcbm_st, 2'b01);
        check("timeout doe", tcbm_doe, 0);
        check("timeout ack", tcbm_ack, 1);
        @(negedge phi2);
        check("timeout pulse width", timeout_err, 0);
        repeat (4) @(negedge phi2);
        check("timeout st held", tcbm_st, 2'b01);
        wr(8'h82, 8'h19);
        check("timeout st cleared", tcbm_st, 2'b00);

        // Asynchronous reset while a byte is held.
        rx_mode = 1;
        rx_exp.push_back({1'b0, 8'h3C});
        phase(8'h82, "rst code");
        @(posedge phi2); #1;
        tcbm_din = 8'h3C;
        tcbm_dav = 1'b0;
        n = 0;
        do begin
            @(negedge phi2);
            n++;
        end while (!rx_valid && n < 200);
        check("rst rx_valid before", rx_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("rst ack", tcbm_ack, 1);
        check("rst rx_valid", rx_valid, 0);
        check("rst doe", tcbm_doe, 0);
        rx_exp.delete();
        tcbm_dav = 1'b1;
        repeat (3) @(posedge phi2);
        #1;
        reset = 1'b0;
        rx_mode = 0;
        wr(8'h81, 8'hE7);

        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            case ($urandom_range(0, 4))
                0: wr(8'h81, d);
                1: wr(8'h82, d);
                2: rd(8'h83, d, 2'($urandom));
                3: rd(8'h84, d, 2'($urandom));
                default: begin
                    c = 8'($urandom);
                    if (c >= 8'h81 && c <= 8'h84) c = c ^ 8'h40;
                    unk(c);
                end
            endcase
        end

        repeat (5) @(negedge phi2);
        check("rx queue drained", rx_exp.size(), 0);
        check("rd queue drained", rd_exp.size(), 0);
        check("timeout pulse count", n_timeouts, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
